// File: rtl/ro_pkg.sv
// Shared widths, state encoding and small helpers for the ring-oscillator
// sample writer and its line packer.
package ro_pkg;

  localparam int COUNT_WIDTH = 32;
  localparam int LINE_WIDTH  = 512;
  localparam int SPL         = LINE_WIDTH / COUNT_WIDTH;
  localparam int SLOT_WIDTH  = $clog2(SPL);

  typedef enum logic [2:0] {
    IDLE,
    START,
    CAPTURE,
    DRAIN,
    WAIT_DMA,
    DONE
  } state_t;

  typedef logic [SLOT_WIDTH-1:0] slot_t;

  // True when the next stored sample finishes the current line.
  function automatic logic is_last_slot(input slot_t slot);
    return slot == slot_t'(SPL - 1);
  endfunction

  // Capture is actively consuming samples or starting up.
  function automatic logic is_sampling(input state_t state);
    return (state == START) || (state == CAPTURE);
  endfunction

  // States in which an early DMA completion must be remembered.
  function automatic logic is_busy(input state_t state);
    return (state == START) || (state == CAPTURE) || (state == DRAIN);
  endfunction

endpackage

// File: rtl/ro_line_packer.sv
// Packs RO count samples into cache lines and double-buffers each finished
// line in a hold register until the DMA write channel accepts it.
module ro_line_packer
  import ro_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   capture_en,
  input  logic                   sample_valid,
  input  logic [COUNT_WIDTH-1:0] sample_data,
  input  logic                   dma_full,
  output logic                   line_done,
  output logic                   drop,
  output logic                   line_valid,
  output logic                   wr_en,
  output logic [LINE_WIDTH-1:0]  wr_data
);

  slot_t                 slot_q, slot_d;
  logic [LINE_WIDTH-1:0] line_q, line_d;
  logic [LINE_WIDTH-1:0] hold_q, hold_d;
  logic                  line_valid_q, line_valid_d;

  logic                  accept;
  logic                  last_slot;
  logic                  store;
  logic [LINE_WIDTH-1:0] ins_mask;
  logic [LINE_WIDTH-1:0] ins_word;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no branch can
    // leave one unassigned and infer a latch.
    slot_d       = slot_q;
    line_d       = line_q;
    hold_d       = hold_q;
    line_valid_d = line_valid_q;

    accept    = capture_en & sample_valid;
    last_slot = is_last_slot(slot_q);
    wr_en     = line_valid_q & ~dma_full;

    // A completing sample has nowhere to go while the held line is stuck.
    drop      = accept & last_slot & line_valid_q & ~wr_en;
    store     = accept & ~drop;
    line_done = store & last_slot;

    ins_mask = LINE_WIDTH'({COUNT_WIDTH{1'b1}}) << (COUNT_WIDTH * slot_q);
    ins_word = LINE_WIDTH'(sample_data) << (COUNT_WIDTH * slot_q);

    if (store) begin
      line_d = (line_q & ~ins_mask) | ins_word;
      slot_d = last_slot ? '0 : slot_q + slot_t'(1);
    end

    // A line completing in the same cycle as a write reloads the hold register.
    if (line_done) begin
      hold_d       = line_d;
      line_valid_d = 1'b1;
    end else if (wr_en) begin
      line_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of every other flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_q       <= '0;
      line_valid_q <= 1'b0;
      // NOTE: the line and hold buffers are plain flops rather than RAM, so
      // they are cleared here to keep dma_wr_data at zero after an abort.
      line_q       <= '0;
      hold_q       <= '0;
    end else begin
      slot_q       <= slot_d;
      line_valid_q <= line_valid_d;
      line_q       <= line_d;
      hold_q       <= hold_d;
    end
  end

  assign line_valid = line_valid_q;
  assign wr_data    = hold_q;

endmodule

// File: rtl/ro_sample_writer.sv
// Capture controller: starts the RO sampler and the DMA write, counts packed
// lines, and reports done/overflow back to the memory map.
module ro_sample_writer
  import ro_pkg::*;
#(
  parameter int ADDR_WIDTH = 64,
  parameter int SIZE_WIDTH = 17
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [SIZE_WIDTH-1:0]  num_samples,
  output logic                   done,
  output logic                   overflow,
  output logic                   sample_en,
  input  logic                   sample_valid,
  input  logic [COUNT_WIDTH-1:0] sample_data,
  output logic                   dma_wr_go,
  output logic [ADDR_WIDTH-1:0]  dma_wr_addr,
  output logic [SIZE_WIDTH-1:0]  dma_wr_size,
  output logic                   dma_wr_en,
  output logic [LINE_WIDTH-1:0]  dma_wr_data,
  input  logic                   dma_full,
  input  logic                   dma_wr_done
);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [SIZE_WIDTH-1:0]   size_q, size_d;
  logic [SIZE_WIDTH-1:0]   line_cnt_q, line_cnt_d;
  logic                    done_q, done_d;
  logic                    overflow_q, overflow_d;
  logic                    wdone_seen_q, wdone_seen_d;

  logic [SIZE_WIDTH-1:0]   line_cnt_inc;
  logic                    capture_en;
  logic                    line_done;
  logic                    drop;
  logic                    line_valid;

  ro_line_packer u_packer (
    .clk          (clk),
    .rst          (rst),
    .capture_en   (capture_en),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .dma_full     (dma_full),
    .line_done    (line_done),
    .drop         (drop),
    .line_valid   (line_valid),
    .wr_en        (dma_wr_en),
    .wr_data      (dma_wr_data)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    size_d       = size_q;
    line_cnt_d   = line_cnt_q;
    done_d       = done_q;
    overflow_d   = overflow_q;
    wdone_seen_d = wdone_seen_q;

    capture_en   = (state_q == CAPTURE);
    sample_en    = is_sampling(state_q);
    dma_wr_go    = (state_q == START);
    line_cnt_inc = line_cnt_q + SIZE_WIDTH'(1);

    if (line_done) begin
      line_cnt_d = line_cnt_inc;
    end
    if (drop) begin
      overflow_d = 1'b1;
    end
    // The DMA may finish before we reach WAIT_DMA; remember it.
    if (dma_wr_done && is_busy(state_q)) begin
      wdone_seen_d = 1'b1;
    end

    case (state_q)
      IDLE, DONE: begin
        if (go) begin
          addr_d       = wr_addr;
          size_d       = num_samples;
          line_cnt_d   = '0;
          overflow_d   = 1'b0;
          wdone_seen_d = 1'b0;
          if (num_samples == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = START;
            done_d  = 1'b0;
          end
        end
      end
      START: begin
        state_d = CAPTURE;
      end
      CAPTURE: begin
        if (line_done && (line_cnt_inc == size_q)) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!line_valid) begin
          state_d = WAIT_DMA;
        end
      end
      WAIT_DMA: begin
        if (dma_wr_done || wdone_seen_q) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      size_q       <= '0;
      line_cnt_q   <= '0;
      done_q       <= 1'b0;
      overflow_q   <= 1'b0;
      wdone_seen_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      size_q       <= size_d;
      line_cnt_q   <= line_cnt_d;
      done_q       <= done_d;
      overflow_q   <= overflow_d;
      wdone_seen_q <= wdone_seen_d;
    end
  end

  assign done        = done_q;
  assign overflow    = overflow_q;
  assign dma_wr_addr = addr_q;
  assign dma_wr_size = size_q;

endmodule
